// File: rtl/gate_xor.sv
// Parameterised bitwise XOR with a registered copy, any-difference flag and Hamming distance.
// Optional saturating count of differing cycles when GATE_XOR_STATS_EN is defined.
module gate_xor #(
    parameter int unsigned n     = 4,
    parameter int unsigned CNT_W = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       en,
    input  logic [n-1:0]               A,
    input  logic [n-1:0]               B,
    output logic [n-1:0]               F,
    output logic [n-1:0]               F_q,
    output logic                       any_diff_q,
    output logic [$clog2(n+1)-1:0]     pop_q,
    output logic [CNT_W-1:0]           diff_cycles
);

    localparam int unsigned POP_W = $clog2(n + 1);

    logic [POP_W-1:0] pop_c;
    logic             any_diff_c;

    assign F          = A ^ B;
    assign any_diff_c = |F;

    // Hamming distance of A vs B; POP_W always holds the value n
    always_comb begin
        pop_c = '0;
        for (int unsigned i = 0; i < n; i++) begin
            pop_c = pop_c + POP_W'(F[i]);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            F_q        <= '0;
            any_diff_q <= 1'b0;
            pop_q      <= '0;
        end else if (en) begin
            F_q        <= F;
            any_diff_q <= any_diff_c;
            pop_q      <= pop_c;
        end
    end

`ifdef GATE_XOR_STATS_EN
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic [CNT_W-1:0] cnt_q;

    // Saturating count of enabled cycles where the operands differ
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (en && any_diff_c && (cnt_q != CNT_MAX)) begin
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    assign diff_cycles = cnt_q;
`else
    assign diff_cycles = '0;
`endif

endmodule

// File: tb/tb_gate_xor.sv
// Randomised self-checking bench for gate_xor against a behavioural model.
// Expectations for diff_cycles follow GATE_XOR_STATS_EN.
module tb_gate_xor;

    localparam int unsigned N     = 4;
    localparam int unsigned CW    = 2;
    localparam int unsigned PW    = $clog2(N + 1);
    localparam int          CMAX  = (1 << CW) - 1;

    logic          clk;
    logic          rst;
    logic          en;
    logic [N-1:0]  A;
    logic [N-1:0]  B;
    logic [N-1:0]  F;
    logic [N-1:0]  F_q;
    logic          any_diff_q;
    logic [PW-1:0] pop_q;
    logic [CW-1:0] diff_cycles;

    int n_checks = 0;
    int n_errors = 0;

    // behavioural model state
    int m_fq, m_any, m_pop, m_cnt;

    gate_xor #(.n(N), .CNT_W(CW)) dut (
        .clk(clk), .rst(rst), .en(en), .A(A), .B(B),
        .F(F), .F_q(F_q), .any_diff_q(any_diff_q), .pop_q(pop_q),
        .diff_cycles(diff_cycles)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // One cycle: drive mid-cycle, check F immediately, then check registered outputs after the edge
    task automatic apply(input logic r, input logic e, input logic [N-1:0] a, input logic [N-1:0] b);
        int d;
        @(negedge clk);
        rst = r; en = e; A = a; B = b;
        #1;
        d = int'(a) ^ int'(b);
        check("F", 32'(F), 32'(d));
        @(posedge clk);
        if (r) begin
            m_fq = 0; m_any = 0; m_pop = 0; m_cnt = 0;
        end else if (e) begin
            m_fq  = d;
            m_any = (d != 0) ? 1 : 0;
            m_pop = $countones(d);
`ifdef GATE_XOR_STATS_EN
            if (d != 0 && m_cnt < CMAX) m_cnt = m_cnt + 1;
`endif
        end
        #1;
        check("F_q", 32'(F_q), 32'(m_fq));
        check("any_diff_q", 32'(any_diff_q), 32'(m_any));
        check("pop_q", 32'(pop_q), 32'(m_pop));
        check("diff_cycles", 32'(diff_cycles), 32'(m_cnt));
    endtask

    initial begin
        logic [N-1:0] ra, rb;
        rst = 1'b0; en = 1'b0; A = '0; B = '0;
        m_fq = 0; m_any = 0; m_pop = 0; m_cnt = 0;

        // reset state, F live during reset
        apply(1'b1, 1'b1, 4'b1010, 4'b0101);
        check("reset_F_q", 32'(F_q), 32'd0);

        apply(1'b0, 1'b1, 4'b1010, 4'b0101);
        check("all_diff_pop", 32'(pop_q), 32'd4);
        check("all_diff_fq", 32'(F_q), 32'hF);
        apply(1'b0, 1'b1, 4'b1100, 4'b1111);
        check("two_diff_pop", 32'(pop_q), 32'd2);
        apply(1'b0, 1'b1, 4'b0000, 4'b1111);
        apply(1'b0, 1'b1, 4'b0110, 4'b0110);
        check("equal_any", 32'(any_diff_q), 32'd0);

        // hold while en low
        apply(1'b0, 1'b1, 4'b1010, 4'b0101);
        apply(1'b0, 1'b0, 4'b0000, 4'b0000);
        apply(1'b0, 1'b0, 4'b0011, 4'b0000);
        check("hold_fq", 32'(F_q), 32'hF);
        check("hold_pop", 32'(pop_q), 32'd4);

        // mid-stream reset, then saturation run
        apply(1'b1, 1'b1, 4'b1010, 4'b0101);
        for (int i = 0; i < 5; i++) begin
            apply(1'b0, 1'b1, 4'b1010, 4'b0101);
`ifdef GATE_XOR_STATS_EN
            check("sat_seq", 32'(diff_cycles), 32'((i < 3) ? i + 1 : 3));
`else
            check("cnt_off", 32'(diff_cycles), 32'd0);
`endif
        end

        // randomised traffic
        for (int i = 0; i < 300; i++) begin
            ra = N'($urandom);
            rb = ($urandom_range(0, 3) == 0) ? ra : N'($urandom);
            apply(($urandom_range(0, 19) == 0), ($urandom_range(0, 3) != 0), ra, rb);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/gate_xor.md
Name: gate_xor

Overview:
- Parameterised n-bit bitwise XOR block with a zero-latency combinational result.
- Adds a registered copy of the result plus per-cycle difference statistics: any-bit-differs flag and popcount (Hamming distance of A vs B).
- Used as a comparator/difference primitive in datapath checking logic.
- Single clock domain, synchronous active-high reset.

Parameters:
- n, 4, operand/result width in bits; legal range n >= 1.
- CNT_W, 16, width of the optional difference-cycle counter; legal range CNT_W >= 1.

Ports:
- clk  input  1  system clock; all registers update on its rising edge.
- rst  input  1  synchronous reset, active-high.
- en  input  1  register-update enable; when low, registered outputs hold.
- A  input  n  operand A.
- B  input  n  operand B.
- F  output  n  combinational A ^ B.
- F_q  output  n  registered A ^ B.
- any_diff_q  output  1  registered reduction-OR of A ^ B.
- pop_q  output  $clog2(n+1)  registered popcount of A ^ B; 1 bit when n=1 gives width 1.
- diff_cycles  output  CNT_W  saturating count of enabled cycles with any_diff; optional feature.

Behaviour:
- F = A ^ B, purely combinational, bit i = A[i] XOR B[i]:
  - Zero latency; settles within the same delta/propagation time.
  - Independent of clk, rst and en.
  - X/Z on an input bit propagates to the corresponding F bit per standard XOR semantics.
- Registered outputs F_q, any_diff_q, pop_q:
  - Rising edge with rst=1: all clear to 0 (diff_cycles also 0). rst has priority over en.
  - Rising edge with rst=0, en=1: F_q <= A ^ B; any_diff_q <= |(A ^ B); pop_q <= number of 1 bits in A ^ B.
  - Rising edge with rst=0, en=0: all registered outputs hold.
- Latency: registered outputs reflect inputs sampled at edge k, visible after edge k. Exactly 1 cycle.
- pop_q range is 0..n; the width always holds n without overflow.
- Reset asserted mid-stream clears registered state on that edge. The first enabled edge after rst deasserts captures fresh data. F is unaffected throughout.
- No handshake and no backpressure; new data is accepted on every enabled edge.

Optional Feature:
- Macro GATE_XOR_STATS_EN.
- Defined:
  - diff_cycles increments by 1 on each rising edge with rst=0, en=1 and (A ^ B) != 0.
  - It saturates at 2^CNT_W-1 and never wraps.
  - It clears to 0 on rst.
- Not defined:
  - The diff_cycles port remains present but is tied constant 0.
  - No counter logic is synthesised.

Test Plan:
- n=4, A=4'b1010, B=4'b0101, wait 10 ns -> F=4'b1111. After an enabled edge: F_q=4'b1111, any_diff_q=1, pop_q=4.
- A=4'b1100, B=4'b1111 -> F=4'b0011. After an enabled edge: F_q=4'b0011, any_diff_q=1, pop_q=2.
- A=4'b0000, B=4'b1111 -> F=4'b1111. Then A=B=4'b0110 -> F=0; after an edge any_diff_q=0, pop_q=0, and diff_cycles does not increment.
- Load A=1010, B=0101 with en=1, then drop en and change inputs to A=B=0 -> F=0 immediately; F_q stays 1111 and pop_q stays 4 while en=0.
- Assert rst for 1 cycle mid-stream with A=1010, B=0101, en=1 -> after that edge F_q=0, any_diff_q=0, pop_q=0, diff_cycles=0, while F=1111 throughout.
- With GATE_XOR_STATS_EN defined and CNT_W=2, hold differing inputs with en=1 for 5 edges -> diff_cycles reads 1, 2, 3, 3, 3 (saturated). Without the macro -> diff_cycles=0 always.
